// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit.
//
// Fetches 16-bit Hack instructions over a req/ack instruction port. A-instructions load A
// directly. C-instructions are decoded into controls for an external combinational ALU. The
// unit sequences optional data-memory reads and writes over a re/we/ack port, then commits the
// results to A, D and PC. Jumps are resolved from the ALU zr/ng flags.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   imem_req/addr/ack/data  instruction fetch handshake; addr is the PC
//   dmem_re/we/addr/wdata/ack/rdata  data memory handshake
//   alu_x, alu_y          ALU operands (D, and A or MDR selected by IR[12])
//   alu_zx..alu_no        ALU control bits, taken from IR[11:6]
//   alu_out, alu_zr, alu_ng  ALU result and flags
//   pc                    current PC, for debug
//   retire                one-cycle pulse per completed instruction
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        retire
);

  typedef enum logic [1:0] {StFetch, StMread, StExec, StMwrite} state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_a, w_a_nxt;
  logic [15:0] r_d, w_d_nxt;
  logic [14:0] r_pc, w_pc_nxt;
  // Only IR[12:0] is kept: IR[15] is always 1 for a stored C-instruction and IR[14:13] are
  // don't-care bits.
  logic [12:0] r_ir, w_ir_nxt;
  logic [15:0] r_mdr, w_mdr_nxt;
  logic [14:0] r_waddr, w_waddr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic        r_retire, w_retire_nxt;

  logic [14:0] w_pc_inc;
  logic        w_jump;

  assign w_pc_inc = r_pc + 15'd1;
  assign w_jump   = (r_ir[2] & alu_ng) | (r_ir[1] & alu_zr) | (r_ir[0] & ~alu_ng & ~alu_zr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StFetch;
      r_a      <= 16'h0000;
      r_d      <= 16'h0000;
      r_pc     <= RESET_PC;
      r_ir     <= 13'h0000;
      r_mdr    <= 16'h0000;
      r_waddr  <= 15'h0000;
      r_wdata  <= 16'h0000;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_d      <= w_d_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_mdr    <= w_mdr_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_retire <= w_retire_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_d_nxt      = r_d;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_mdr_nxt    = r_mdr;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;
    w_retire_nxt = 1'b0;
    unique case (r_state)
      StFetch: begin
        if (imem_ack) begin
          if (!imem_data[15]) begin
            w_a_nxt      = {1'b0, imem_data[14:0]};
            w_pc_nxt     = w_pc_inc;
            w_retire_nxt = 1'b1;
          end else begin
            w_ir_nxt    = imem_data[12:0];
            w_state_nxt = imem_data[12] ? StMread : StExec;
          end
        end
      end
      StMread: begin
        if (dmem_ack) begin
          w_mdr_nxt   = dmem_rdata;
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        // Jump target and write address use A as it was before this edge.
        if (r_ir[5]) w_a_nxt = alu_out;
        if (r_ir[4]) w_d_nxt = alu_out;
        w_pc_nxt = w_jump ? r_a[14:0] : w_pc_inc;
        if (r_ir[3]) begin
          w_waddr_nxt = r_a[14:0];
          w_wdata_nxt = alu_out;
          w_state_nxt = StMwrite;
        end else begin
          w_retire_nxt = 1'b1;
          w_state_nxt  = StFetch;
        end
      end
      StMwrite: begin
        if (dmem_ack) begin
          w_retire_nxt = 1'b1;
          w_state_nxt  = StFetch;
        end
      end
      default: w_state_nxt = StFetch;
    endcase
  end

  // Requests are gated by rst_n so nothing is asserted during a reset cycle.
  assign imem_req   = rst_n & (r_state == StFetch);
  assign imem_addr  = r_pc;
  assign dmem_re    = rst_n & (r_state == StMread);
  assign dmem_we    = rst_n & (r_state == StMwrite);
  assign dmem_addr  = (r_state == StMwrite) ? r_waddr : r_a[14:0];
  assign dmem_wdata = r_wdata;

  assign alu_x  = r_d;
  assign alu_y  = r_ir[12] ? r_mdr : r_a;
  assign alu_zx = r_ir[11];
  assign alu_nx = r_ir[10];
  assign alu_zy = r_ir[9];
  assign alu_ny = r_ir[8];
  assign alu_f  = r_ir[7];
  assign alu_no = r_ir[6];

  assign pc     = r_pc;
  assign retire = r_retire;

endmodule
